sobel_line_ctrl: RTL

SOBEL_LINE_CTRL -- requirements
Module: sobel_line_ctrl

---
 rtl/sobel_pkg.sv | 20 ++
 rtl/sobel_line_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel line-buffer controller.
// FSM encoding, pixel width and the counter-width helper live here.
package sobel_pkg;

  localparam int DATA_W        = 8;
  localparam int IMG_WIDTH_DEF = 640;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL0 = 3'd1,
    FILL1 = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4
  } state_t;

  function automatic int col_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/sobel_line_ctrl.sv
// Line-buffer controller feeding a 3x3 Sobel window from two external FIFOs.
// FIFO0 holds line n-1, FIFO1 holds line n-2; rows leave column-aligned.
module sobel_line_ctrl #(
  parameter int IMG_WIDTH = sobel_pkg::IMG_WIDTH_DEF,
  parameter int DATA_W    = sobel_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              f0_wr_en,
  output logic              f0_rd_en,
  output logic [DATA_W-1:0] f0_wr_data,
  input  logic [DATA_W-1:0] f0_rd_data,
  input  logic              f0_rd_empty,
  input  logic              f0_wr_full,
  output logic              f1_wr_en,
  output logic              f1_rd_en,
  output logic [DATA_W-1:0] f1_wr_data,
  input  logic [DATA_W-1:0] f1_rd_data,
  input  logic              f1_rd_empty,
  input  logic              f1_wr_full,
  output logic [DATA_W-1:0] row0,
  output logic [DATA_W-1:0] row1,
  output logic [DATA_W-1:0] row2,
  output logic              win_valid,
  output logic              ovf_err,
  output logic              unf_err
);
  import sobel_pkg::*;

  localparam int CW = col_w(IMG_WIDTH);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic              f1_wr_en_q, f1_wr_en_d;
  logic [DATA_W-1:0] row2_q, row2_d;
  logic              win_q, win_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      col_q      <= '0;
      f1_wr_en_q <= 1'b0;
      row2_q     <= '0;
      win_q      <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      f1_wr_en_q <= f1_wr_en_d;
      row2_q     <= row2_d;
      win_q      <= win_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row2_d     = row2_q;
    win_d      = 1'b0;
    f1_wr_en_d = 1'b0;
    f0_wr_en   = 1'b0;
    f0_rd_en   = 1'b0;
    f1_rd_en   = 1'b0;
    f0_wr_data = '0;
    unique case (state_q)
      IDLE: begin
        if (vsync) begin
          state_d = FILL0;
          col_d   = '0;
        end
      end
      FILL0, FILL1, RUN: begin
        if (vsync) begin
          // New frame mid-stream: flush, the same-cycle pixel is lost.
          state_d = DRAIN;
          col_d   = '0;
        end else if (pix_valid) begin
          f0_wr_en   = 1'b1;
          f0_wr_data = pix_data;
          f0_rd_en   = (state_q != FILL0);
          f1_rd_en   = (state_q == RUN);
          f1_wr_en_d = f0_rd_en;
          row2_d     = pix_data;
          win_d      = (state_q == RUN);
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (state_q == FILL0) state_d = FILL1;
            if (state_q == FILL1) state_d = RUN;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        f0_rd_en = !f0_rd_empty;
        f1_rd_en = !f1_rd_empty;
        col_d    = '0;
        // Wait for a trailing FIFO1 write so nothing stale survives.
        if (f0_rd_empty && f1_rd_empty && !f1_wr_en_q) begin
          state_d = FILL0;
        end
      end
      default: state_d = IDLE;
    endcase

    f1_wr_en   = f1_wr_en_q;
    f1_wr_data = f1_wr_en_q ? f0_rd_data : '0;

    ovf_d = ovf_q
          | (f0_wr_en & f0_wr_full)
          | (f1_wr_en_q & f1_wr_full);
    unf_d = unf_q
          | ((state_q != DRAIN)
             & ((f0_rd_en & f0_rd_empty)
              | (f1_rd_en & f1_rd_empty)));
  end

  assign row2      = row2_q;
  assign row1      = win_q ? f0_rd_data : '0;
  assign row0      = win_q ? f1_rd_data : '0;
  assign win_valid = win_q;
  assign ovf_err   = ovf_q;
  assign unf_err   = unf_q;

endmodule
